// File: rtl/sm_monitor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sm_monitor_pkg
// Purpose  : Shared types for the protected-module violation monitor.
//            Holds the violation-cause encodings, the FSM state type, the
//            per-slot configuration record and a region-membership helper.
// Ports    : (package - none)
// Revision : 1.0 - initial release
// ============================================================================
package sm_monitor_pkg;

  // Slot records store bounds at this fixed width; narrower address buses
  // are zero-extended, which keeps unsigned comparisons exact.
  localparam int MAX_ADDR_W = 32;

  localparam logic [1:0] VT_NONE  = 2'd0;
  localparam logic [1:0] VT_ENTRY = 2'd1;
  localparam logic [1:0] VT_DATA  = 2'd2;
  localparam logic [1:0] VT_CODE  = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  typedef struct packed {
    logic                  enabled;
    logic [MAX_ADDR_W-1:0] txt_start;
    logic [MAX_ADDR_W-1:0] txt_stop;
    logic [MAX_ADDR_W-1:0] dat_start;
    logic [MAX_ADDR_W-1:0] dat_stop;
  } slot_t;

  // Half-open [s, e); an empty or inverted region never matches.
  function automatic logic in_region(input logic [MAX_ADDR_W-1:0] a,
                                     input logic [MAX_ADDR_W-1:0] s,
                                     input logic [MAX_ADDR_W-1:0] e);
    return (s < e) && (a >= s) && (a < e);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sm_range_check.sv
`default_nettype none
// ============================================================================
// Module   : sm_range_check
// Purpose  : Combinational per-slot checker producing the three hit flags.
// Ports    : slot_i                     - slot configuration record
//            pc_i, prev_pc_i            - current / previous PC (zero-extended)
//            data_en_i, data_wr_i       - data access valid / is write
//            data_addr_i                - data access address (zero-extended)
//            hit_entry_o/data_o/code_o  - entry, data, code-access hits
// Revision : 1.0 - initial release
// ============================================================================
module sm_range_check
  import sm_monitor_pkg::*;
(
  input  slot_t                 slot_i,
  input  logic [MAX_ADDR_W-1:0] pc_i,
  input  logic [MAX_ADDR_W-1:0] prev_pc_i,
  input  logic                  data_en_i,
  input  logic                  data_wr_i,
  input  logic [MAX_ADDR_W-1:0] data_addr_i,
  output logic                  hit_entry_o,
  output logic                  hit_data_o,
  output logic                  hit_code_o
);

  logic w_pc_in_txt;
  logic w_prev_in_txt;
  logic w_addr_in_txt;
  logic w_addr_in_dat;

  assign w_pc_in_txt   = in_region(pc_i,        slot_i.txt_start, slot_i.txt_stop);
  assign w_prev_in_txt = in_region(prev_pc_i,   slot_i.txt_start, slot_i.txt_stop);
  assign w_addr_in_txt = in_region(data_addr_i, slot_i.txt_start, slot_i.txt_stop);
  assign w_addr_in_dat = in_region(data_addr_i, slot_i.dat_start, slot_i.dat_stop);

  // Jumping into the code region anywhere but its first word.
  assign hit_entry_o = slot_i.enabled && w_pc_in_txt && !w_prev_in_txt &&
                       (pc_i != slot_i.txt_start);

  assign hit_data_o  = slot_i.enabled && data_en_i && w_addr_in_dat && !w_pc_in_txt;

  // Writes into the code region are illegal even from the module itself.
  assign hit_code_o  = slot_i.enabled && data_en_i && w_addr_in_txt &&
                       (!w_pc_in_txt || data_wr_i);

endmodule
`default_nettype wire

// File: rtl/sm_violation_monitor.sv
`default_nettype none
// ============================================================================
// Module   : sm_violation_monitor
// Purpose  : Watches PC and data accesses against NUM_SM protected regions
//            and holds a CPU reset request for RST_HOLD cycles on violation.
// Ports    : mclk, puc_rst                  - clock, sync active-high reset
//            pc, prev_pc                    - current / previous PC
//            data_en, data_wr, data_addr    - data access
//            cfg_we, cfg_idx, cfg_*         - slot configuration write
//            cfg_err                        - rejected configuration pulse
//            reset                          - CPU reset request
//            viol_id, viol_type, viol_cnt   - last cause and saturating count
// Revision : 1.0 - initial release
// ============================================================================
module sm_violation_monitor
  import sm_monitor_pkg::*;
#(
  parameter int NUM_SM   = 4,
  parameter int ADDR_W   = 16,
  parameter int RST_HOLD = 8
) (
  input  logic              mclk,
  input  logic              puc_rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] prev_pc,
  input  logic              data_en,
  input  logic              data_wr,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic              cfg_we,
  input  logic [3:0]        cfg_idx,
  input  logic [ADDR_W-1:0] cfg_txt_start,
  input  logic [ADDR_W-1:0] cfg_txt_stop,
  input  logic [ADDR_W-1:0] cfg_dat_start,
  input  logic [ADDR_W-1:0] cfg_dat_stop,
  input  logic              cfg_enable,
  output logic              cfg_err,
  output logic              reset,
  output logic [3:0]        viol_id,
  output logic [1:0]        viol_type,
  output logic [7:0]        viol_cnt
);

  // Counter holds RST_HOLD-1 down to 0, so reset lasts exactly RST_HOLD cycles.
  localparam int              HOLD_W    = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RST_HOLD - 1);

  state_t            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [3:0]        id_q, id_d;
  logic [1:0]        type_q, type_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              cfg_err_q, cfg_err_d;
  slot_t             slots_q [NUM_SM];
  slot_t             slots_d [NUM_SM];

  logic [NUM_SM-1:0] w_hit_entry, w_hit_data, w_hit_code;
  logic              w_viol;
  logic [3:0]        w_id;
  logic [1:0]        w_type;
  logic              w_accept;

  for (genvar g = 0; g < NUM_SM; g++) begin : g_slot
    sm_range_check u_range_check (
      .slot_i      (slots_q[g]),
      .pc_i        (MAX_ADDR_W'(pc)),
      .prev_pc_i   (MAX_ADDR_W'(prev_pc)),
      .data_en_i   (data_en),
      .data_wr_i   (data_wr),
      .data_addr_i (MAX_ADDR_W'(data_addr)),
      .hit_entry_o (w_hit_entry[g]),
      .hit_data_o  (w_hit_data[g]),
      .hit_code_o  (w_hit_code[g])
    );
  end

  // Descending scan so the lowest-indexed hitting slot overrides the rest.
  always_comb begin
    w_viol = 1'b0;
    w_id   = 4'd0;
    w_type = VT_NONE;
    for (int i = NUM_SM - 1; i >= 0; i--) begin
      if (w_hit_entry[i] || w_hit_data[i] || w_hit_code[i]) begin
        w_viol = 1'b1;
        w_id   = 4'(i);
        w_type = w_hit_entry[i] ? VT_ENTRY : (w_hit_data[i] ? VT_DATA : VT_CODE);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    id_d     = id_q;
    type_d   = type_q;
    cnt_d    = cnt_q;
    w_accept = 1'b0;
    case (state_q)
      ST_IDLE: w_accept = w_viol;
      ST_HOLD: begin
        if (hold_q == '0) begin
          // Last hold cycle: a fresh violation continues reset seamlessly.
          if (w_viol) w_accept = 1'b1;
          else        state_d  = ST_IDLE;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (w_accept) begin
      state_d = ST_HOLD;
      hold_d  = HOLD_LOAD;
      id_d    = w_id;
      type_d  = w_type;
      cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    end
  end

  always_comb begin
    cfg_err_d = cfg_we && (int'(cfg_idx) >= NUM_SM);
    for (int i = 0; i < NUM_SM; i++) begin
      slots_d[i] = slots_q[i];
      if (cfg_we && (cfg_idx == 4'(i))) begin
        if (!cfg_enable) begin
          slots_d[i].enabled = 1'b0;
        end else if (slots_q[i].enabled) begin
          cfg_err_d = 1'b1;
        end else begin
          slots_d[i].enabled   = 1'b1;
          slots_d[i].txt_start = MAX_ADDR_W'(cfg_txt_start);
          slots_d[i].txt_stop  = MAX_ADDR_W'(cfg_txt_stop);
          slots_d[i].dat_start = MAX_ADDR_W'(cfg_dat_start);
          slots_d[i].dat_stop  = MAX_ADDR_W'(cfg_dat_stop);
        end
      end
    end
  end

  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      state_q   <= ST_IDLE;
      hold_q    <= '0;
      id_q      <= 4'd0;
      type_q    <= VT_NONE;
      cnt_q     <= 8'd0;
      cfg_err_q <= 1'b0;
      for (int i = 0; i < NUM_SM; i++) slots_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      id_q      <= id_d;
      type_q    <= type_d;
      cnt_q     <= cnt_d;
      cfg_err_q <= cfg_err_d;
      for (int i = 0; i < NUM_SM; i++) slots_q[i] <= slots_d[i];
    end
  end

  assign reset     = (state_q == ST_HOLD);
  assign cfg_err   = cfg_err_q;
  assign viol_id   = id_q;
  assign viol_type = type_q;
  assign viol_cnt  = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_sm_violation_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_sm_violation_monitor
// Purpose  : Self-checking bench for sm_violation_monitor with a behavioural
//            reference model of slots, violation rules and reset hold time.
// Ports    : (testbench - none)
// Revision : 1.0 - initial release
// ============================================================================
module tb_sm_violation_monitor;

  localparam int NUM_SM   = 4;
  localparam int ADDR_W   = 16;
  localparam int RST_HOLD = 8;

  logic              mclk = 1'b0;
  logic              puc_rst;
  logic [ADDR_W-1:0] pc, prev_pc, data_addr;
  logic              data_en, data_wr;
  logic              cfg_we, cfg_enable;
  logic [3:0]        cfg_idx;
  logic [ADDR_W-1:0] cfg_txt_start, cfg_txt_stop, cfg_dat_start, cfg_dat_stop;
  logic              cfg_err, reset;
  logic [3:0]        viol_id;
  logic [1:0]        viol_type;
  logic [7:0]        viol_cnt;
  logic [15:0]       act;

  always #5 mclk = ~mclk;

  sm_violation_monitor #(.NUM_SM(NUM_SM), .ADDR_W(ADDR_W), .RST_HOLD(RST_HOLD)) dut (
    .mclk(mclk), .puc_rst(puc_rst), .pc(pc), .prev_pc(prev_pc),
    .data_en(data_en), .data_wr(data_wr), .data_addr(data_addr),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_txt_start(cfg_txt_start), .cfg_txt_stop(cfg_txt_stop),
    .cfg_dat_start(cfg_dat_start), .cfg_dat_stop(cfg_dat_stop),
    .cfg_enable(cfg_enable), .cfg_err(cfg_err), .reset(reset),
    .viol_id(viol_id), .viol_type(viol_type), .viol_cnt(viol_cnt)
  );

  assign act = {reset, cfg_err, viol_id, viol_type, viol_cnt};

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: slot table plus "cycles of reset still owed".
  int m_ts [16], m_te [16], m_ds [16], m_de [16];
  bit m_en [16];
  int m_hold, m_id, m_type, m_cnt;
  bit m_err;

  function automatic bit in_rng(int a, int s, int e);
    return (a >= s) && (a < e);
  endfunction

  function automatic logic [15:0] exp_vec();
    logic [15:0] v;
    v = {(m_hold > 0), m_err, 4'(m_id), 2'(m_type), 8'(m_cnt)};
    return v;
  endfunction

  task automatic model_step();
    int win_id, win_t, p, pp, da, idx;
    bit pin;
    win_id = 0;
    win_t  = 0;
    p  = int'(pc);
    pp = int'(prev_pc);
    da = int'(data_addr);
    if (puc_rst) begin
      for (int i = 0; i < 16; i++) begin
        m_en[i] = 0; m_ts[i] = 0; m_te[i] = 0; m_ds[i] = 0; m_de[i] = 0;
      end
      m_hold = 0; m_id = 0; m_type = 0; m_cnt = 0; m_err = 0;
    end else begin
      for (int i = 0; i < NUM_SM; i++) begin
        if (m_en[i] && win_t == 0) begin
          pin = in_rng(p, m_ts[i], m_te[i]);
          if (pin && !in_rng(pp, m_ts[i], m_te[i]) && p != m_ts[i]) win_t = 1;
          else if (data_en && in_rng(da, m_ds[i], m_de[i]) && !pin) win_t = 2;
          else if (data_en && in_rng(da, m_ts[i], m_te[i]) && (!pin || data_wr)) win_t = 3;
          if (win_t != 0) win_id = i;
        end
      end
      m_err = 0;
      if (cfg_we) begin
        idx = int'(cfg_idx);
        if (idx >= NUM_SM) m_err = 1;
        else if (cfg_enable && m_en[idx]) m_err = 1;
        else if (cfg_enable) begin
          m_en[idx] = 1;
          m_ts[idx] = int'(cfg_txt_start); m_te[idx] = int'(cfg_txt_stop);
          m_ds[idx] = int'(cfg_dat_start); m_de[idx] = int'(cfg_dat_stop);
        end else m_en[idx] = 0;
      end
      if (m_hold > 1) m_hold--;
      else if (win_t != 0) begin
        m_hold = RST_HOLD; m_id = win_id; m_type = win_t;
        if (m_cnt < 255) m_cnt++;
      end else m_hold = 0;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge mclk);
    #1;
  endtask

  task automatic idle_inputs();
    puc_rst = 0; pc = 16'h8000; prev_pc = 16'h8000; data_en = 0; data_wr = 0;
    data_addr = 16'h0; cfg_we = 0; cfg_enable = 0; cfg_idx = 4'd0;
    cfg_txt_start = 0; cfg_txt_stop = 0; cfg_dat_start = 0; cfg_dat_stop = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    puc_rst = 1;
    tick();
    puc_rst = 0;
  endtask

  task automatic cfg_write(int idx, int ts, int te, int ds, int de, bit en);
    cfg_we = 1; cfg_idx = 4'(idx); cfg_enable = en;
    cfg_txt_start = 16'(ts); cfg_txt_stop = 16'(te);
    cfg_dat_start = 16'(ds); cfg_dat_stop = 16'(de);
    tick();
    cfg_we = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    // Reset must win over a simultaneous violation-looking access and config write.
    puc_rst = 1; cfg_we = 1; cfg_enable = 1; cfg_idx = 4'd0;
    cfg_txt_start = 16'h0; cfg_txt_stop = 16'hFFFF; pc = 16'h0010; prev_pc = 16'hFFFF;
    tick();
    tick();
    n_checks++;
    if (act !== 16'h0000) begin
      n_fail++; $display("FAIL reset_state: got %h expected %h", act, 16'h0000);
    end
    do_reset();
    n_checks++;
    if (act !== exp_vec()) begin
      n_fail++; $display("FAIL reset_model: got %h expected %h", act, exp_vec());
    end
  endtask

  task automatic test_entry();
    int hi;
    do_reset();
    cfg_write(0, 'hA000, 'hA400, 'h0500, 'h0C00, 1);
    n_checks++;
    if (act !== exp_vec()) begin
      n_fail++; $display("FAIL entry_cfg: got %h expected %h", act, exp_vec());
    end
    pc = 16'hA010; prev_pc = 16'h8000;
    tick();
    idle_inputs();
    n_checks++;
    if (reset !== 1'b1 || viol_id !== 4'd0 || viol_type !== 2'd1 || viol_cnt !== 8'd1) begin
      n_fail++; $display("FAIL entry_cause: got %h expected %h", act, 16'h8101);
    end
    hi = 1;
    for (int i = 0; i < 11; i++) begin
      tick();
      if (reset === 1'b1) hi++;
      n_checks++;
      if (act !== exp_vec()) begin
        n_fail++; $display("FAIL entry_hold_cyc%0d: got %h expected %h", i, act, exp_vec());
      end
    end
    n_checks++;
    if (hi != RST_HOLD) begin
      n_fail++; $display("FAIL entry_hold_len: got %0d expected %0d", hi, RST_HOLD);
    end
  endtask

  task automatic test_data_code();
    do_reset();
    cfg_write(0, 'hA000, 'hA400, 'h0500, 'h0C00, 1);
    pc = 16'h8000; prev_pc = 16'h8000; data_en = 1; data_addr = 16'h0600;
    tick();
    idle_inputs();
    n_checks++;
    if (reset !== 1'b1 || viol_type !== 2'd2 || viol_id !== 4'd0) begin
      n_fail++; $display("FAIL data_viol: got %h expected %h", act, 16'h8201);
    end
    for (int i = 0; i < RST_HOLD; i++) tick();
    pc = 16'hA100; prev_pc = 16'hA100; data_en = 1; data_addr = 16'h0600;
    tick();
    n_checks++;
    if (reset !== 1'b0 || act !== exp_vec()) begin
      n_fail++; $display("FAIL data_owner_ok: got %h expected %h", act, exp_vec());
    end
    data_wr = 1; data_addr = 16'hA200;
    tick();
    idle_inputs();
    n_checks++;
    if (reset !== 1'b1 || viol_type !== 2'd3 || viol_cnt !== 8'd2) begin
      n_fail++; $display("FAIL code_write: got %h expected %h", act, 16'h8302);
    end
    for (int i = 0; i < RST_HOLD; i++) tick();
    pc = 16'hA100; prev_pc = 16'hA100; data_en = 1; data_wr = 1; data_addr = 16'hA400;
    tick();
    n_checks++;
    if (reset !== 1'b0 || act !== exp_vec()) begin
      n_fail++; $display("FAIL code_stop_bound: got %h expected %h", act, exp_vec());
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    cfg_write(1, 'h1000, 'h1100, 'h2000, 'h2100, 1);
    cfg_write(3, 'h3000, 'h3100, 'h2000, 'h2100, 1);
    pc = 16'h8000; prev_pc = 16'h8000; data_en = 1; data_addr = 16'h2050;
    tick();
    n_checks++;
    if (viol_id !== 4'd1 || viol_type !== 2'd2 || viol_cnt !== 8'd1) begin
      n_fail++; $display("FAIL priority_id: got %h expected %h", act, 16'h8601);
    end
    data_addr = 16'h1050;  // code-region read from outside, slot 1
    tick();
    n_checks++;
    if (viol_cnt !== 8'd1 || viol_type !== 2'd2) begin
      n_fail++; $display("FAIL hold_ignore: got %h expected %h", act, 16'h8601);
    end
    // Keep violating: reset must stay high across the hold boundary.
    for (int i = 0; i < 9; i++) begin
      tick();
      n_checks++;
      if (reset !== 1'b1 || act !== exp_vec()) begin
        n_fail++; $display("FAIL b2b_cyc%0d: got %h expected %h", i, act, exp_vec());
      end
    end
    n_checks++;
    if (viol_cnt !== 8'd2 || viol_type !== 2'd3) begin
      n_fail++; $display("FAIL b2b_reenter: got %h expected %h", act, 16'h8702);
    end
  endtask

  task automatic test_cfg();
    do_reset();
    cfg_write(0, 'hA000, 'hA400, 'h0500, 'h0C00, 1);
    cfg_write(0, 'h1111, 'h2222, 'h3333, 'h4444, 1);
    n_checks++;
    if (cfg_err !== 1'b1) begin
      n_fail++; $display("FAIL reenable_err: got %b expected %b", cfg_err, 1'b1);
    end
    tick();
    n_checks++;
    if (cfg_err !== 1'b0) begin
      n_fail++; $display("FAIL err_pulse: got %b expected %b", cfg_err, 1'b0);
    end
    cfg_write(5, 'h0, 'h10, 'h0, 'h10, 1);
    n_checks++;
    if (cfg_err !== 1'b1) begin
      n_fail++; $display("FAIL idx_range_err: got %b expected %b", cfg_err, 1'b1);
    end
    pc = 16'hA010; prev_pc = 16'h8000;  // only violates if bounds unchanged
    tick();
    idle_inputs();
    n_checks++;
    if (reset !== 1'b1 || viol_type !== 2'd1 || act !== exp_vec()) begin
      n_fail++; $display("FAIL bounds_kept: got %h expected %h", act, exp_vec());
    end
    tick();
    tick();  // now in hold cycle 3
    puc_rst = 1;
    tick();
    puc_rst = 0;
    n_checks++;
    if (reset !== 1'b0 || viol_cnt !== 8'd0) begin
      n_fail++; $display("FAIL rst_in_hold: got %h expected %h", act, 16'h0000);
    end
    cfg_write(2, 'hA000, 'hA400, 'h0500, 'h0C00, 1);
    cfg_write(2, 'h0, 'h0, 'h0, 'h0, 0);
    pc = 16'hA010; prev_pc = 16'h8000;
    tick();
    idle_inputs();
    n_checks++;
    if (reset !== 1'b0 || act !== exp_vec()) begin
      n_fail++; $display("FAIL released_slot: got %h expected %h", act, exp_vec());
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int s = 0; s < NUM_SM; s++)
      cfg_write(s, $urandom_range(0, 40), $urandom_range(0, 63),
                $urandom_range(0, 40), $urandom_range(0, 63), 1);
    for (int c = 0; c < 3000; c++) begin
      pc        = 16'($urandom_range(0, 63));
      prev_pc   = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 63)) : pc;
      data_addr = 16'($urandom_range(0, 63));
      data_en   = 1'($urandom_range(0, 1));
      data_wr   = 1'($urandom_range(0, 1));
      cfg_we    = ($urandom_range(0, 99) < 4);
      cfg_idx   = 4'($urandom_range(0, 6));
      cfg_enable = 1'($urandom_range(0, 1));
      cfg_txt_start = 16'($urandom_range(0, 40)); cfg_txt_stop = 16'($urandom_range(0, 63));
      cfg_dat_start = 16'($urandom_range(0, 40)); cfg_dat_stop = 16'($urandom_range(0, 63));
      puc_rst   = ($urandom_range(0, 299) == 0);
      tick();
      n_checks++;
      if (act !== exp_vec()) begin
        n_fail++; $display("FAIL random_cyc%0d: got %h expected %h", c, act, exp_vec());
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    m_hold = 0; m_id = 0; m_type = 0; m_cnt = 0; m_err = 0;
    for (int i = 0; i < 16; i++) begin
      m_en[i] = 0; m_ts[i] = 0; m_te[i] = 0; m_ds[i] = 0; m_de[i] = 0;
    end
    test_reset();
    test_entry();
    test_data_code();
    test_back_to_back();
    test_cfg();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/sm_violation_monitor.md
SM_VIOLATION_MONITOR -- requirements
Module: sm_violation_monitor

Interface
REQ-001 SHALL have parameter NUM_SM, default 4, number of protected-module slots (1..16).
REQ-002 SHALL have parameter ADDR_W, default 16, address/PC width.
REQ-003 SHALL have parameter RST_HOLD, default 8, cycles reset is held per violation (>=1).
REQ-004 SHALL have port mclk  in  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port puc_rst  in  1  reset, synchronous and active-high.
REQ-006 SHALL have ports pc, prev_pc  in  ADDR_W  current/previous instruction address.
REQ-007 SHALL have ports data_en, data_wr  in  1  data access valid / access is a write.
REQ-008 SHALL have port data_addr  in  ADDR_W  data access address.
REQ-009 SHALL have port cfg_we  in  1  one-cycle slot-configuration write strobe.
REQ-010 SHALL have port cfg_idx  in  4  target slot index.
REQ-011 SHALL have ports cfg_txt_start, cfg_txt_stop, cfg_dat_start, cfg_dat_stop  in  ADDR_W  region bounds.
REQ-012 SHALL have port cfg_enable  in  1  1 = protect slot, 0 = release slot.
REQ-013 SHALL have port cfg_err  out  1  one-cycle pulse, configuration write rejected.
REQ-014 SHALL have port reset  out  1  CPU reset request.
REQ-015 SHALL have ports viol_id  out  4, viol_type  out  2  latched cause of last violation.
REQ-016 SHALL have port viol_cnt  out  8  saturating count of accepted violations.

Function
REQ-017 Each slot SHALL hold txt/dat start/stop and an enabled flag; regions are half-open [start, stop).
REQ-018 A slot with start >= stop for a region SHALL never match that region.
REQ-019 Entry violation (type 1): enabled slot i, pc in txt_i, prev_pc not in txt_i, pc != txt_start_i.
REQ-020 Data violation (type 2): data_en=1, data_addr in dat_i, pc not in txt_i (reads and writes).
REQ-021 Code-access violation (type 3): data_en=1, data_addr in txt_i, pc not in txt_i; data_wr=1 inside txt_i SHALL be type 3 even when pc in txt_i.
REQ-022 Simultaneous hits: lowest slot index wins; within a slot, type 1 > 2 > 3.
REQ-023 FSM states IDLE, HOLD; IDLE->HOLD on any violation, HOLD->IDLE when hold counter reaches 0.
REQ-024 Violation detected combinationally in cycle t SHALL give reset=1 from cycle t+1 for exactly RST_HOLD cycles.
REQ-025 On IDLE->HOLD, viol_id/viol_type SHALL latch the winning cause and viol_cnt SHALL increment, saturating at 255.
REQ-026 Violations during HOLD SHALL be ignored (no relatch, no count); a violation in the cycle HOLD exits SHALL re-enter HOLD next cycle with no gap.
REQ-027 cfg_we with cfg_idx >= NUM_SM SHALL be ignored and pulse cfg_err next cycle.
REQ-028 cfg_we with cfg_enable=1 to an already-enabled slot SHALL be rejected (cfg_err), slot unchanged.
REQ-029 cfg_we with cfg_enable=0 SHALL clear the enabled flag only; bounds retained.
REQ-030 An accepted configuration write SHALL affect checks from the following cycle; writes accepted in both FSM states.

Reset
REQ-031 puc_rst=1 SHALL force: FSM IDLE, reset=0, cfg_err=0, viol_id=0, viol_type=0, viol_cnt=0, all slots disabled, bounds 0.
REQ-032 puc_rst asserted during HOLD SHALL drop reset next cycle and discard the remaining hold count.
REQ-033 puc_rst SHALL take priority over simultaneous cfg_we and violations.

Structure
REQ-034 Package sm_monitor_pkg SHALL hold violation-type encodings (NONE=0, ENTRY=1, DATA=2, CODE=3), FSM state type, and slot-record typedef.
REQ-035 Sub-module sm_range_check (combinational, one instance per slot) SHALL produce the three per-slot hit flags.

Verification
REQ-036 Slot 0 txt A000-A400, dat 0500-0C00; pc=A010, prev_pc=8000 -> reset=1 next cycle for 8 cycles, viol_id=0, viol_type=1.
REQ-037 Same config; pc=8000, data_en=1, data_addr=0600 -> type 2; pc=A100, same access -> no violation.
REQ-038 pc=A100, data_en=1, data_wr=1, data_addr=A200 -> type 3; data_addr=A400 (stop) -> no violation.
REQ-039 Slots 1 and 3 both hit type 2 in the same cycle -> viol_id=1; second violation in HOLD -> viol_cnt stays 1.
REQ-040 Re-enable enabled slot 0 -> cfg_err pulse, bounds unchanged; cfg_idx=5 with NUM_SM=4 -> cfg_err; puc_rst in HOLD cycle 3 -> reset=0 next cycle, viol_cnt=0.
